adc_pair_decimator: RTL and testbench

//  Downstream consumer of the dual-channel 12-bit ADC serial interface.

---
 rtl/adc_pair_decimator.sv | 179 +++++++++++++++++
 tb/tb_adc_pair_decimator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pair_decimator.sv
`default_nettype none
// ============================================================================
// Module      : adc_pair_decimator
// Description : Boxcar averager for dual 12-bit ADC sample pairs with a
//               first-word-fall-through output FIFO (valid/ready).
//               Optional macro AVG_ROUND_EN selects round-half-up averaging.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pair_decimator #(
    parameter int LOG2_N    = 4,
    parameter int FIFO_LOG2 = 2
) (
    input  logic        nReset,
    input  logic        Clk,
    input  logic        Clear,
    input  logic        Enable,
    input  logic [11:0] InA,
    input  logic [11:0] InB,
    input  logic        InValid,
    output logic [11:0] OutA,
    output logic [11:0] OutB,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Overflow
);

    localparam int c_N     = 1 << LOG2_N;
    localparam int c_ACC_W = 12 + LOG2_N;
    localparam int c_CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam int c_DEPTH = 1 << FIFO_LOG2;
    localparam int c_PTR_W = FIFO_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    logic [c_ACC_W-1:0] acc_a_q, acc_a_d;
    logic [c_ACC_W-1:0] acc_b_q, acc_b_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               pipe_valid_q, pipe_valid_d;
    logic [11:0]        pipe_a_q, pipe_a_d;
    logic [11:0]        pipe_b_q, pipe_b_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [23:0]        mem_q [c_DEPTH];
    logic [23:0]        mem_d [c_DEPTH];
    logic [11:0]        out_a_q, out_a_d;
    logic [11:0]        out_b_q, out_b_d;
    logic               overflow_q, overflow_d;

    logic               w_accept;
    logic               w_last;
    logic [c_ACC_W-1:0] w_sum_a;
    logic [c_ACC_W-1:0] w_sum_b;
    logic [11:0]        w_avg_a;
    logic [11:0]        w_avg_b;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_accept = InValid & Enable & ~Clear;
    assign w_last   = (count_q == c_LAST);
    // The accumulator holds at most (N-1)*4095, so adding one more sample fits.
    assign w_sum_a  = acc_a_q + c_ACC_W'(InA);
    assign w_sum_b  = acc_b_q + c_ACC_W'(InB);

`ifdef AVG_ROUND_EN
    localparam logic [c_ACC_W:0] c_ROUND = (c_ACC_W + 1)'(c_N >> 1);
    logic [c_ACC_W:0] w_rnd_a;
    logic [c_ACC_W:0] w_rnd_b;
    assign w_rnd_a = {1'b0, w_sum_a} + c_ROUND;
    assign w_rnd_b = {1'b0, w_sum_b} + c_ROUND;
    assign w_avg_a = w_rnd_a[LOG2_N +: 12];
    assign w_avg_b = w_rnd_b[LOG2_N +: 12];
`else
    assign w_avg_a = w_sum_a[LOG2_N +: 12];
    assign w_avg_b = w_sum_b[LOG2_N +: 12];
`endif

    always_comb begin
        acc_a_d      = acc_a_q;
        acc_b_d      = acc_b_q;
        count_d      = count_q;
        pipe_valid_d = 1'b0;
        pipe_a_d     = pipe_a_q;
        pipe_b_d     = pipe_b_q;
        if (Clear) begin
            acc_a_d = '0;
            acc_b_d = '0;
            count_d = '0;
        end else if (w_accept) begin
            if (w_last) begin
                pipe_valid_d = 1'b1;
                pipe_a_d     = w_avg_a;
                pipe_b_d     = w_avg_b;
                acc_a_d      = '0;
                acc_b_d      = '0;
                count_d      = '0;
            end else begin
                acc_a_d = w_sum_a;
                acc_b_d = w_sum_b;
                count_d = count_q + c_CNT_W'(1);
            end
        end
    end

    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                      (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    assign w_pop    = ~w_empty & OutReady;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push   = pipe_valid_q & (~w_full | w_pop);
    assign w_drop   = pipe_valid_q & w_full & ~w_pop;
    assign OutValid = ~w_empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        overflow_d = overflow_q;
        if (Clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q[FIFO_LOG2-1:0]] = {pipe_a_q, pipe_b_q};
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            if (w_drop) begin
                overflow_d = 1'b1;
            end
            // Output register tracks the next head; it holds when the FIFO drains.
            if (wr_ptr_d != rd_ptr_d) begin
                {out_a_d, out_b_d} = mem_d[rd_ptr_d[FIFO_LOG2-1:0]];
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            acc_a_q      <= '0;
            acc_b_q      <= '0;
            count_q      <= '0;
            pipe_valid_q <= 1'b0;
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '{default: '0};
            out_a_q      <= '0;
            out_b_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            acc_a_q      <= acc_a_d;
            acc_b_q      <= acc_b_d;
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_a_q     <= pipe_a_d;
            pipe_b_q     <= pipe_b_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            overflow_q   <= overflow_d;
        end
    end

    assign OutA     = out_a_q;
    assign OutB     = out_b_q;
    assign Overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_pair_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_pair_decimator
// Description : Directed + random bench for adc_pair_decimator against a
//               queue-based reference model (honours AVG_ROUND_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_pair_decimator;

    localparam int LOG2_N    = 2;
    localparam int FIFO_LOG2 = 2;
    localparam int N         = 1 << LOG2_N;
    localparam int DEPTH     = 1 << FIFO_LOG2;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        Clear = 1'b0;
    logic        Enable = 1'b0;
    logic [11:0] InA = '0;
    logic [11:0] InB = '0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [11:0] OutA;
    logic [11:0] OutB;
    logic        OutValid;
    logic        Overflow;

    adc_pair_decimator #(.LOG2_N(LOG2_N), .FIFO_LOG2(FIFO_LOG2)) dut (
        .nReset(nReset), .Clk(Clk), .Clear(Clear), .Enable(Enable),
        .InA(InA), .InB(InB), .InValid(InValid),
        .OutA(OutA), .OutB(OutB), .OutValid(OutValid),
        .OutReady(OutReady), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int samp_a[$];
    int samp_b[$];
    bit pend_v;
    int pend_a, pend_b;
    int fq_a[$];
    int fq_b[$];
    int m_out_a, m_out_b;
    bit m_ovf;

    int n_assert = 0;
    int n_fail   = 0;
    int pops;

    function automatic int avg_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
`ifdef AVG_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    function automatic int exp_avg4(input int s);
`ifdef AVG_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("OutValid", {31'd0, OutValid}, (fq_a.size() != 0) ? 32'd1 : 32'd0);
        chk("OutA", {20'd0, OutA}, m_out_a);
        chk("OutB", {20'd0, OutB}, m_out_b);
        chk("Overflow", {31'd0, Overflow}, {31'd0, m_ovf});
    endtask

    task automatic model_reset();
        samp_a.delete(); samp_b.delete();
        fq_a.delete(); fq_b.delete();
        pend_v = 0; pend_a = 0; pend_b = 0;
        m_out_a = 0; m_out_b = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit pop;
        int sz;
        if (Clear) begin
            samp_a.delete(); samp_b.delete();
            fq_a.delete(); fq_b.delete();
            pend_v = 0; m_ovf = 0;
        end else begin
            sz  = fq_a.size();
            pop = (sz != 0) && OutReady;
            if (pop) begin
                void'(fq_a.pop_front());
                void'(fq_b.pop_front());
            end
            if (pend_v) begin
                if (sz == DEPTH && !pop) m_ovf = 1;
                else begin
                    fq_a.push_back(pend_a);
                    fq_b.push_back(pend_b);
                end
            end
            if (fq_a.size() != 0) begin
                m_out_a = fq_a[0];
                m_out_b = fq_b[0];
            end
            pend_v = 0;
            if (InValid && Enable) begin
                samp_a.push_back(int'(InA));
                samp_b.push_back(int'(InB));
                if (samp_a.size() == N) begin
                    pend_a = avg_of(samp_a);
                    pend_b = avg_of(samp_b);
                    pend_v = 1;
                    samp_a.delete(); samp_b.delete();
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input int a, input int b);
        InValid = v;
        InA = a[11:0];
        InB = b[11:0];
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic rnd_samples(input int n);
        for (int i = 0; i < n; i++) cyc(1, $urandom_range(0, 4095), $urandom_range(0, 4095));
    endtask

    task automatic drain(output int cnt);
        OutReady = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!OutValid) break;
            cnt++;
            cyc(0, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge Clk);
        nReset = 1'b1;
        Enable = 1'b1;

        // Basic average, latency of two edges
        OutReady = 1'b1;
        cyc(1, 100, 4095); cyc(1, 101, 4095); cyc(1, 102, 4095); cyc(1, 103, 4095);
        chk("t1_pre_valid", {31'd0, OutValid}, 32'd0);
        cyc(0, 0, 0);
        chk("t1_valid", {31'd0, OutValid}, 32'd1);
        chk("t1_A", {20'd0, OutA}, exp_avg4(406));
        chk("t1_B", {20'd0, OutB}, 32'd4095);
        idle(3);

        // Fill past capacity: fifth average dropped, Overflow sticky
        OutReady = 1'b0;
        rnd_samples(5 * N);
        idle(3);
        chk("t2_ovf", {31'd0, Overflow}, 32'd1);
        drain(pops);
        chk("t2_drain", pops, 32'd4);
        chk("t2_ovf_hold", {31'd0, Overflow}, 32'd1);

        // Clear with queued entries, partial sum and same-edge InValid
        OutReady = 1'b0;
        rnd_samples(2 * N);
        idle(2);
        rnd_samples(3);
        Clear = 1'b1;
        cyc(1, 500, 500);
        Clear = 1'b0;
        chk("t4_valid", {31'd0, OutValid}, 32'd0);
        chk("t4_ovf", {31'd0, Overflow}, 32'd0);
        OutReady = 1'b1;
        cyc(1, 8, 8); cyc(1, 8, 8); cyc(1, 8, 8); cyc(1, 8, 8);
        cyc(0, 0, 0);
        chk("t4_valid_out", {31'd0, OutValid}, 32'd1);
        chk("t4_A", {20'd0, OutA}, 32'd8);
        cyc(0, 0, 0);
        chk("t4_single", {31'd0, OutValid}, 32'd0);

        // Full FIFO: push and pop on the same edge
        OutReady = 1'b0;
        rnd_samples(4 * N);
        cyc(0, 0, 0);
        rnd_samples(N);
        OutReady = 1'b1;
        cyc(0, 0, 0);
        OutReady = 1'b0;
        chk("t3_ovf", {31'd0, Overflow}, 32'd0);
        idle(2);
        drain(pops);
        chk("t3_drain", pops, 32'd4);

        // Enable low ignores samples and keeps the partial sum
        OutReady = 1'b1;
        cyc(1, 10, 1); cyc(1, 20, 2);
        Enable = 1'b0;
        cyc(1, 4000, 4095); cyc(1, 4000, 4095);
        Enable = 1'b1;
        cyc(1, 30, 3); cyc(1, 40, 5);
        cyc(0, 0, 0);
        chk("t5_valid", {31'd0, OutValid}, 32'd1);
        chk("t5_A", {20'd0, OutA}, exp_avg4(100));
        chk("t5_B", {20'd0, OutB}, exp_avg4(11));
        idle(2);

        // Random traffic with occasional Clear and Enable gaps
        for (int i = 0; i < 400; i++) begin
            Clear    = ($urandom_range(0, 99) == 0);
            Enable   = ($urandom_range(0, 7) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            cyc($urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 4095));
        end
        Clear  = 1'b0;
        Enable = 1'b1;

        // Asynchronous reset mid-accumulation with a full FIFO
        OutReady = 1'b0;
        rnd_samples(4 * N);
        cyc(0, 0, 0);
        rnd_samples(2);
        chk("t6_full", {31'd0, OutValid}, 32'd1);
        nReset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge Clk);
        nReset = 1'b1;
        OutReady = 1'b1;
        cyc(1, 4000, 7); cyc(1, 4000, 7); cyc(1, 4000, 7);
        chk("t6_count0", {31'd0, OutValid}, 32'd0);
        cyc(1, 4000, 7);
        cyc(0, 0, 0);
        chk("t6_valid", {31'd0, OutValid}, 32'd1);
        chk("t6_A", {20'd0, OutA}, 32'd4000);
        chk("t6_B", {20'd0, OutB}, 32'd7);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
